// File: rtl/fetcher.sv
`default_nettype none
// ============================================================================
// Module      : fetcher
// Description : Instruction fetch/issue unit. Reads a 4-word instruction
//               (header + 3 argument words) from a 1-cycle-latency memory,
//               decodes the header into one-hot command flags and presents
//               the command to the executor until it signals completion,
//               then advances the PC sequentially or by a jump offset.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               imem_addr / imem_rdata - instruction memory word port
//               exe_flag, cmd_flags,
//               cmd_args               - command presented to the executor
//               ready_flag, jmp_flag,
//               new_exe_addr_offset    - executor completion / branch result
//               pc, halted, error      - status
// Revision    : 1.0 - initial release
// ============================================================================
module fetcher #(
    parameter int unsigned              ADDRESS_SIZE  = 32,
    parameter int unsigned              WORD_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0]  RESET_PC      = '0,
    parameter int unsigned              READY_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [ADDRESS_SIZE-1:0]   imem_addr,
    input  logic [WORD_SIZE-1:0]      imem_rdata,
    output logic                      exe_flag,
    output logic [5:0]                cmd_flags,
    output logic [3*WORD_SIZE-1:0]    cmd_args,
    input  logic                      ready_flag,
    input  logic                      jmp_flag,
    input  logic [ADDRESS_SIZE-1:0]   new_exe_addr_offset,
    output logic [ADDRESS_SIZE-1:0]   pc,
    output logic                      halted,
    output logic                      error
);

    localparam logic [1:0]  c_ST_FETCH     = 2'd0;
    localparam logic [1:0]  c_ST_ISSUE     = 2'd1;
    localparam logic [1:0]  c_ST_HALT      = 2'd2;
    localparam logic        c_TIMEOUT_EN   = (READY_TIMEOUT != 0);
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(READY_TIMEOUT - 1);
    localparam logic [ADDRESS_SIZE-1:0] c_SEQ_STEP = ADDRESS_SIZE'(4);

    logic [1:0]                 r_state;
    logic [2:0]                 r_k;
    logic [ADDRESS_SIZE-1:0]    r_pc;
    logic [5:0]                 r_hdr_flags;
    logic [WORD_SIZE-1:0]       r_w1;
    logic [WORD_SIZE-1:0]       r_w2;
    logic [31:0]                r_wait;
    logic                       r_exe;
    logic [5:0]                 r_cmd_flags;
    logic [3*WORD_SIZE-1:0]     r_cmd_args;
    logic                       r_halted;
    logic                       r_error;

    logic [5:0]                 w_hdr_bits;
    logic                       w_onehot;

    assign w_hdr_bits = imem_rdata[5:0];
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_onehot   = (w_hdr_bits != 6'd0) &&
                        ((w_hdr_bits & (w_hdr_bits - 6'd1)) == 6'd0);

    // Address runs one word ahead of capture: k=0..3 addresses pc..pc+3,
    // the data for address k is captured on the edge that leaves k+1.
    assign imem_addr = r_pc + {{(ADDRESS_SIZE-3){1'b0}}, r_k};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_FETCH;
            r_k         <= 3'd0;
            r_pc        <= RESET_PC;
            r_hdr_flags <= 6'd0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_wait      <= 32'd0;
            r_exe       <= 1'b0;
            r_cmd_flags <= 6'd0;
            r_cmd_args  <= '0;
            r_halted    <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FETCH: begin
                    case (r_k)
                        3'd0: r_k <= 3'd1;
                        3'd1: begin
                            // Header word arrives; HALT bit takes precedence
                            // over the one-hot legality check.
                            if (imem_rdata[WORD_SIZE-1]) begin
                                r_state  <= c_ST_HALT;
                                r_halted <= 1'b1;
                            end else if (!w_onehot) begin
                                r_state  <= c_ST_HALT;
                                r_halted <= 1'b1;
                                r_error  <= 1'b1;
                            end else begin
                                r_hdr_flags <= w_hdr_bits;
                                r_k         <= 3'd2;
                            end
                        end
                        3'd2: begin
                            r_w1 <= imem_rdata;
                            r_k  <= 3'd3;
                        end
                        3'd3: begin
                            r_w2 <= imem_rdata;
                            r_k  <= 3'd4;
                        end
                        default: begin
                            // Last argument word: publish the whole command
                            // at once so the executor never sees a partial one.
                            r_cmd_args  <= {imem_rdata, r_w2, r_w1};
                            r_cmd_flags <= r_hdr_flags;
                            r_exe       <= 1'b1;
                            r_wait      <= 32'd0;
                            r_k         <= 3'd0;
                            r_state     <= c_ST_ISSUE;
                        end
                    endcase
                end

                c_ST_ISSUE: begin
                    if (ready_flag) begin
                        r_exe       <= 1'b0;
                        r_cmd_flags <= 6'd0;
                        r_pc        <= jmp_flag ? (r_pc + new_exe_addr_offset)
                                                : (r_pc + c_SEQ_STEP);
                        r_state     <= c_ST_FETCH;
                    end else if (c_TIMEOUT_EN && (r_wait == c_TIMEOUT_LAST)) begin
                        r_exe       <= 1'b0;
                        r_cmd_flags <= 6'd0;
                        r_halted    <= 1'b1;
                        r_error     <= 1'b1;
                        r_state     <= c_ST_HALT;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end

                default: begin
                    // Absorbing until reset.
                    r_exe       <= 1'b0;
                    r_cmd_flags <= 6'd0;
                end
            endcase
        end
    end

    assign exe_flag  = r_exe;
    assign cmd_flags = r_cmd_flags;
    assign cmd_args  = r_cmd_args;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign error     = r_error;

endmodule
`default_nettype wire
